// File: rtl/rounding_sched_pkg.sv
// Shared defaults and constants for the rounding round-robin scheduler.
package rounding_sched_pkg;
  localparam int DEFAULT_NREQ      = 4;
  localparam int DEFAULT_LOG2_NREQ = 2;
  // Zero operands bypass the rounding unit, which has no notion of "no MSB set".
  localparam bit ZERO_BYPASS       = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/Rounding_unit.sv
// Rounds a non-zero operand to the nearest power of two (ties round up).
module Rounding_unit #(
  parameter int WIDTH      = 16,
  parameter int ROUN_WIDTH = 0,
  parameter int LOG2_WIDTH = 4
) (
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   rounded
);
  logic [LOG2_WIDTH-1:0] msb;
  logic                  round_up;
  logic [LOG2_WIDTH:0]   shamt;
  logic [WIDTH:0]        pow;

  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (operand[i]) msb = LOG2_WIDTH'(i);
    end
  end

  // The bit just below the MSB decides whether to step up to the next power.
  assign round_up = (msb != '0) && operand[msb - 1'b1];
  assign shamt    = {1'b0, msb} + {{LOG2_WIDTH{1'b0}}, round_up};
  assign pow      = {{WIDTH{1'b0}}, 1'b1} << shamt;
  assign rounded  = pow >> ROUN_WIDTH;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import rounding_sched_pkg::*;
#(
  parameter int NREQ      = DEFAULT_NREQ,
  parameter int LOG2_NREQ = DEFAULT_LOG2_NREQ
) (
  input  logic [NREQ-1:0]      req,
  input  logic [LOG2_NREQ-1:0] ptr,
  input  logic                 enable,
  output logic [NREQ-1:0]      grant,
  output logic [LOG2_NREQ-1:0] grant_idx,
  output logic                 grant_valid
);
  always_comb begin : arb
    int j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (enable && !grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = LOG2_NREQ'(j);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rounding_rr_scheduler.sv
// Shares one Rounding_unit among NREQ requesters: RR grant -> S1 operand reg -> S2 result reg.
module rounding_rr_scheduler
  import rounding_sched_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4,
  parameter int NREQ       = DEFAULT_NREQ,
  parameter int LOG2_NREQ  = DEFAULT_LOG2_NREQ
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          out_data,
  output logic [LOG2_NREQ-1:0]    out_id,
  output logic                    busy
);
  // Handshake: a transfer happens on any edge where valid and ready are both high;
  // ready never depends on data, and out_data/out_id hold while out_valid & ~out_ready.
  logic                 s1_v;
  logic [WIDTH-1:0]     s1_data;
  logic [LOG2_NREQ-1:0] s1_id;
  logic [LOG2_NREQ-1:0] rr_ptr;
  logic [LOG2_NREQ-1:0] grant_idx;
  logic                 grant_valid;
  logic                 adv1, adv2;
  logic [WIDTH-1:0]     grant_data;
  logic [WIDTH:0]       rounded;
  logic [WIDTH:0]       s1_result;

  assign adv2 = ~out_valid | out_ready;
  assign adv1 = ~s1_v | adv2;

  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  rr_arbiter #(.NREQ(NREQ), .LOG2_NREQ(LOG2_NREQ)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .enable      (adv1 & rst_n),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];

  Rounding_unit #(.WIDTH(WIDTH), .ROUN_WIDTH(0), .LOG2_WIDTH(LOG2_WIDTH)) u_round (
    .operand (s1_data),
    .rounded (rounded)
  );

  assign s1_result = (ZERO_BYPASS && (s1_data == '0)) ? '0 : rounded;
  assign busy      = s1_v | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_id   <= '0;
      rr_ptr  <= '0;
    end else begin
      if (adv1) s1_v <= grant_valid;
      if (grant_valid) begin
        s1_data <= grant_data;
        s1_id   <= grant_idx;
        rr_ptr  <= (grant_idx == LOG2_NREQ'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (adv2) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_data <= s1_result;
        out_id   <= s1_id;
      end
    end
  end
endmodule

// File: tb/tb_rounding_rr_scheduler.sv
// Bench for rounding_rr_scheduler: queue-level reference model plus directed literal checks.
module tb_rounding_rr_scheduler;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int LN = 2;
  localparam int EW = 32 + LN + W + 1;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      out_data;
  logic [LN-1:0]   out_id;
  logic            busy;

  rounding_rr_scheduler #(.WIDTH(W), .LOG2_WIDTH(4), .NREQ(N), .LOG2_NREQ(LN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [EW-1:0]   exp_q[$];
  int              rr      = 0;
  int              now     = 0;
  logic [N-1:0]    granted_last = '0;
  int              wait_cnt[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Nearest power of two, ties upward; zero stays zero.
  function automatic logic [W:0] golden(input logic [W-1:0] a);
    longint v, p;
    v = longint'(a);
    p = 1;
    if (v == 0) return '0;
    while (p * 2 <= v) p = p * 2;
    if (p > 1 && (v & (p / 2)) != 0) p = p * 2;
    return (W+1)'(p);
  endfunction

  // scoreboard: one process checks every cycle and advances the model
  always @(negedge clk) begin : cmp
    logic [N-1:0]  exp_grant;
    logic          vis, accept;
    logic [EW-1:0] e;
    int            gj, j;
    if (!rst_n) begin
      exp_q.delete();
      rr = 0;
      granted_last = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      vis = 1'b0;
      e   = '0;
      if (exp_q.size() > 0) begin
        e   = exp_q[0];
        vis = (int'(e[EW-1 -: 32]) + 2 <= now);
      end
      accept    = (exp_q.size() < 2) || out_ready;
      exp_grant = '0;
      gj        = -1;
      for (int off = 0; off < N; off++) begin
        j = (rr + off) % N;
        if (accept && gj < 0 && req_valid[j]) begin
          gj = j;
          exp_grant[j] = 1'b1;
        end
      end
      chk("req_ready", 64'(req_ready), 64'(exp_grant));
      chk("out_valid", 64'(out_valid), 64'(vis));
      chk("busy", 64'(busy), 64'(exp_q.size() > 0));
      if (vis) begin
        chk("out_data", 64'(out_data), 64'(e[W:0]));
        chk("out_id", 64'(out_id), 64'(e[W+LN:W+1]));
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && gj >= 0 && gj != i) begin
          wait_cnt[i]++;
          chk("starvation", 64'(wait_cnt[i] >= N), 64'(0));
        end else if (!req_valid[i] || gj == i) begin
          wait_cnt[i] = 0;
        end
      end
      if (vis && out_ready) void'(exp_q.pop_front());
      if (gj >= 0) begin
        exp_q.push_back({32'(now), LN'(gj), golden(req_data[gj*W +: W])});
        rr = (gj + 1) % N;
      end
      granted_last = req_valid & req_ready;
      now++;
    end
  end

  function automatic logic [W-1:0] rand_data();
    int r;
    r = $urandom_range(0, 14);
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'd1;
      2: return 16'hffff;
      3: return W'(1) << r;
      4: return W'(3) << r;
      default: return W'($urandom_range(0, 65535));
    endcase
  endfunction

  // driver tasks
  task automatic single(input logic [W-1:0] data, input logic [W:0] exp, input string tag);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*W +: W] = data;
    out_ready = 1'b1;
    #3 chk({tag, "_grant"}, 64'(req_ready), 64'h4);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'h1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    chk({tag, "_id"}, 64'(out_id), 64'h2);
  endtask

  task automatic drive_check(input logic [N-1:0] v, input logic [N-1:0] exp, input string tag);
    @(posedge clk); #1;
    req_valid = v;
    #3 chk(tag, 64'(req_ready), 64'(exp));
  endtask

  int xfers;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_id", 64'(out_id), 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    chk("golden_12", 64'(golden(16'd12)), 64'd16);
    chk("golden_10", 64'(golden(16'd10)), 64'd8);
    chk("golden_ffff", 64'(golden(16'hffff)), 64'h10000);
    chk("golden_0", 64'(golden(16'd0)), 64'd0);
    chk("golden_1", 64'(golden(16'd1)), 64'd1);
    chk("golden_3", 64'(golden(16'd3)), 64'd4);

    single(16'd12, 17'd16, "single12");
    single(16'd10, 17'd8, "single10");
    single(16'hffff, 17'h10000, "singleffff");
    single(16'd0, 17'd0, "single0");
    single(16'd1, 17'd1, "single1");

    // all requesters busy, then reset with both stages full
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 1000 + 37);
    req_valid = '1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("busy_before_reset", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("fair_grant", 64'(req_ready), 64'(1 << (k % N)));
      if (k >= 2) begin
        chk("fair_out_valid", 64'(out_valid), 64'h1);
        chk("fair_out_id", 64'(out_id), 64'((k - 2) % N));
      end
      @(posedge clk); #3;
    end

    // backpressure from an empty pipeline
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    out_ready = 1'b0;
    xfers = 0;
    repeat (5) begin
      #3 xfers += $countones(req_valid & req_ready);
      @(posedge clk); #1;
    end
    chk("bp_transfers", 64'(xfers), 64'd2);
    out_ready = 1'b1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // sparse requests and pointer hold
    drive_check(4'b1000, 4'b1000, "sparse_req3");
    drive_check(4'b0110, 4'b0010, "sparse_wrap_req1");
    drive_check(4'b0000, 4'b0000, "sparse_idle");
    drive_check(4'b0000, 4'b0000, "sparse_idle");
    drive_check(4'b0110, 4'b0100, "sparse_ptr_held");
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);

    // randomized traffic honouring the requester hold rule
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (granted_last[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_data[i*W +: W] = rand_data();
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("drain_busy", 64'(busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
